// File: rtl/fir_mem_arbiter.sv
// Two-requester (host loader / FIR engine) round-robin memory arbiter with grant locking.
// Define FIR_ARB_STATS_EN to add the grant/conflict statistics counters and ports.
module fir_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_lock0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_lock1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
`ifdef FIR_ARB_STATS_EN
  ,
  output logic [31:0]       o_gnt_cnt0,
  output logic [31:0]       o_gnt_cnt1,
  output logic [31:0]       o_conflict_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, LOCKED0, LOCKED1} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_lcnt, w_lcnt_nxt, w_lcnt_inc;
  logic              r_ptr, w_ptr_nxt;
  logic              w_gnt0, w_gnt1, w_acc;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_pend0, r_pend1, r_rvalid0, r_rvalid1;

  assign w_lcnt_inc = r_lcnt + 1'b1;
  assign w_acc      = w_gnt0 | w_gnt1;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_lcnt_nxt  = r_lcnt;
    w_ptr_nxt   = r_ptr;
    if (i_rst_n) begin
      unique case (r_state)
        LOCKED0: w_gnt0 = i_req0;
        LOCKED1: w_gnt1 = i_req1;
        default: begin
          // r_ptr is the last-granted index; on contention the other side wins
          if (i_req0 && i_req1) begin
            w_gnt0 = r_ptr;
            w_gnt1 = !r_ptr;
          end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
          end
        end
      endcase
    end
    if (w_gnt0)      w_ptr_nxt = 1'b0;
    else if (w_gnt1) w_ptr_nxt = 1'b1;
    unique case (r_state)
      LOCKED0: begin
        if (!i_req0 || !i_lock0 || w_lcnt_inc == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_lcnt_nxt  = '0;
        end else begin
          w_lcnt_nxt = w_lcnt_inc;
        end
      end
      LOCKED1: begin
        if (!i_req1 || !i_lock1 || w_lcnt_inc == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_lcnt_nxt  = '0;
        end else begin
          w_lcnt_nxt = w_lcnt_inc;
        end
      end
      default: begin
        if (((w_gnt0 && i_lock0) || (w_gnt1 && i_lock1)) && (CNT_MAX > CNT_W'(1))) begin
          w_state_nxt = w_gnt0 ? LOCKED0 : LOCKED1;
          w_lcnt_nxt  = CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_lcnt      <= '0;
      r_ptr       <= 1'b1;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_pend0     <= 1'b0;
      r_pend1     <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lcnt   <= w_lcnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_mem_en <= w_acc;
      r_mem_we <= w_gnt0 ? i_we0 : (w_gnt1 & i_we1);
      if (w_acc) begin
        r_mem_addr  <= w_gnt0 ? i_addr0 : i_addr1;
        r_mem_wdata <= w_gnt0 ? i_wdata0 : i_wdata1;
      end
      // read tag rides one stage behind the command, matching memory latency
      r_pend0   <= w_gnt0 & !i_we0;
      r_pend1   <= w_gnt1 & !i_we1;
      r_rvalid0 <= r_pend0;
      r_rvalid1 <= r_pend1;
    end
  end

  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rvalid0   = r_rvalid0;
  assign o_rvalid1   = r_rvalid1;
  assign o_rdata0    = i_mem_rdata;
  assign o_rdata1    = i_mem_rdata;

`ifdef FIR_ARB_STATS_EN
  logic [31:0] r_gnt_cnt0, r_gnt_cnt1, r_conflict_cnt;

  // with both requesting, exactly one side always loses that cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt_cnt0     <= '0;
      r_gnt_cnt1     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt0)           r_gnt_cnt0     <= r_gnt_cnt0 + 32'd1;
      if (w_gnt1)           r_gnt_cnt1     <= r_gnt_cnt1 + 32'd1;
      if (i_req0 && i_req1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign o_gnt_cnt0     = r_gnt_cnt0;
  assign o_gnt_cnt1     = r_gnt_cnt1;
  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_fir_mem_arbiter.sv
// Bench for fir_mem_arbiter: directed vector table, hand sequences for lock/reset corners,
// then constrained-random traffic against a transaction-level reference model.
module tb_fir_mem_arbiter;
  localparam int MAX_LOCK = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, lock0 = 0, we0 = 0, req1 = 0, lock1 = 0, we1 = 0;
  logic [9:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [7:0] rdata0, rdata1, mem_wdata;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
`ifdef FIR_ARB_STATS_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  fir_mem_arbiter #(.ADDR_W(10), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_lock0(lock0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
    .i_req1(req1), .i_lock1(lock1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
`ifdef FIR_ARB_STATS_EN
    , .o_gnt_cnt0(gnt_cnt0), .o_gnt_cnt1(gnt_cnt1), .o_conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // external synchronous RAM
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: lock owner/count, last winner, expected memory contents and pipeline
  logic [7:0] ref_mem [0:1023];
  int         m_owner = -1, m_lcnt = 0, m_last = 1;
  logic       e_en = 0, e_we = 0;
  logic [9:0] e_addr = '0;
  logic [7:0] e_wdata = '0, e_rd1_data = '0, e_rd2_data = '0;
  int         e_rd1 = -1, e_rd2 = -1;

  task automatic step(input logic r0, l0, w0, input logic [9:0] a0, input logic [7:0] d0,
                      input logic r1, l1, w1, input logic [9:0] a1, input logic [7:0] d1,
                      output logic g0, output logic g1);
    int g;
    logic [1:0] rq, lk;
    @(negedge clk);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) begin
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("rvalid0", rvalid0, e_rd2 == 0);
    chk("rvalid1", rvalid1, e_rd2 == 1);
    if (e_rd2 == 0) chk("rdata0", rdata0, e_rd2_data);
    if (e_rd2 == 1) chk("rdata1", rdata1, e_rd2_data);
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    rq = {r1, r0};
    lk = {l1, l0};
    g = -1;
    if (m_owner >= 0) begin
      if (rq[m_owner]) g = m_owner;
    end else if (r0 && r1) g = 1 - m_last;
    else if (r0) g = 0;
    else if (r1) g = 1;
    chk("gnt0", gnt0, g == 0);
    chk("gnt1", gnt1, g == 1);
    g0 = gnt0;
    g1 = gnt1;
    if (m_owner >= 0) begin
      if (g == m_owner) begin
        m_lcnt++;
        if (!lk[m_owner] || m_lcnt == MAX_LOCK) begin m_owner = -1; m_lcnt = 0; end
      end else begin
        m_owner = -1; m_lcnt = 0;
      end
    end else if (g >= 0 && lk[g]) begin
      m_owner = g; m_lcnt = 1;
    end
    if (g >= 0) m_last = g;
    e_rd2 = e_rd1; e_rd2_data = e_rd1_data; e_rd1 = -1;
    e_en = (g >= 0); e_we = 1'b0;
    if (g == 0) begin e_we = w0; e_addr = a0; e_wdata = d0; end
    if (g == 1) begin e_we = w1; e_addr = a1; e_wdata = d1; end
    if (g >= 0) begin
      if (e_we) ref_mem[e_addr] = e_wdata;
      else begin e_rd1 = g; e_rd1_data = ref_mem[e_addr]; end
    end
  endtask

  task automatic idle(input int n);
    logic x0, x1;
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, x0, x1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1; req1 = 1; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
`ifdef FIR_ARB_STATS_EN
    chk("rst_gnt_cnt0", gnt_cnt0, 0);
    chk("rst_gnt_cnt1", gnt_cnt1, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
`endif
    req0 = 0; req1 = 0; rst_n = 1'b1;
    m_owner = -1; m_lcnt = 0; m_last = 1;
    e_en = 0; e_we = 0; e_rd1 = -1; e_rd2 = -1;
  endtask

  typedef struct {
    logic       r0, r1, w0, w1;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;
    logic       eg0, eg1;
  } vec_t;

  vec_t       tbl [8];
  logic       g0, g1;
  logic       p_r [2], p_l [2], p_w [2];
  logic [9:0] p_a [2];
  logic [7:0] p_d [2];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[256] = 8'hC3;
    ref_mem[256] = 8'hC3;

    tbl[0] = '{1, 0, 1, 0, 10'd0, 10'd0, 8'h05, 8'h00, 1, 0};
    tbl[1] = '{1, 0, 1, 0, 10'd1, 10'd0, 8'h0A, 8'h00, 1, 0};
    tbl[2] = '{1, 0, 1, 0, 10'd2, 10'd0, 8'hF6, 8'h00, 1, 0};
    tbl[3] = '{1, 0, 1, 0, 10'd3, 10'd0, 8'h40, 8'h00, 1, 0};
    tbl[4] = '{1, 1, 0, 0, 10'd10, 10'd300, 8'h00, 8'h00, 1, 0};
    tbl[5] = '{1, 1, 0, 0, 10'd10, 10'd300, 8'h00, 8'h00, 0, 1};
    tbl[6] = '{1, 1, 0, 0, 10'd10, 10'd300, 8'h00, 8'h00, 1, 0};
    tbl[7] = '{1, 1, 0, 0, 10'd10, 10'd300, 8'h00, 8'h00, 0, 1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin idle(2); do_reset(); end
      step(tbl[i].r0, 0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
           tbl[i].r1, 0, tbl[i].w1, tbl[i].a1, tbl[i].d1, g0, g1);
      chk($sformatf("tbl%0d_gnt0", i), g0, tbl[i].eg0);
      chk($sformatf("tbl%0d_gnt1", i), g1, tbl[i].eg1);
    end
    idle(3);

    // lock held past MAX_LOCK while host waits
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(k > 1, 0, 0, 10'd5, 8'h00, 1, 1, 0, 10'(k), 8'h00, g0, g1);
      chk($sformatf("maxlock%0d_gnt1", k), g1, k <= 16);
      chk($sformatf("maxlock%0d_gnt0", k), g0, k == 17);
    end
    idle(3);
`ifdef FIR_ARB_STATS_EN
    chk("maxlock_conflict_cnt", conflict_cnt, 16);
    chk("maxlock_gnt_cnt1", gnt_cnt1, 16);
    chk("maxlock_gnt_cnt0", gnt_cnt0, 1);
`endif

    // lock dropped on the 5th grant
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(k > 1, 0, 0, 10'd7, 8'h00, k <= 5, k < 5, 0, 10'(20 + k), 8'h00, g0, g1);
      chk($sformatf("unlock%0d_gnt1", k), g1, k <= 5);
      chk($sformatf("unlock%0d_gnt0", k), g0, k == 6);
    end
    idle(3);

    // write then read same address back-to-back
    step(0, 0, 0, '0, '0, 1, 0, 1, 10'd256, 8'h7F, g0, g1);
    step(0, 0, 0, '0, '0, 1, 0, 0, 10'd256, 8'h00, g0, g1);
    idle(2);
    chk("raw_rvalid1", rvalid1, 1);
    chk("raw_rdata1", rdata1, 8'h7F);
    idle(2);

    // reset with a read outstanding
    ram[256] = 8'hC3;
    ref_mem[256] = 8'hC3;
    step(0, 0, 0, '0, '0, 1, 0, 0, 10'd256, 8'h00, g0, g1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("rstrd_rvalid1", rvalid1, 0);
    end

    // random traffic
    for (int i = 0; i < 2; i++) p_r[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_r[i]) begin
          p_r[i] = ($urandom_range(0, 9) < 7);
          p_l[i] = ($urandom_range(0, 3) == 0);
          p_w[i] = $urandom_range(0, 1);
          p_a[i] = 10'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 10'h200 : 10'h000);
          p_d[i] = 8'($urandom);
        end
      end
      step(p_r[0], p_l[0], p_w[0], p_a[0], p_d[0], p_r[1], p_l[1], p_w[1], p_a[1], p_d[1], g0, g1);
      if (g0) p_r[0] = 0;
      if (g1) p_r[1] = 0;
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fir_mem_arbiter.md
FIR_MEM_ARBITER -- requirements
Module: fir_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, memory address width; DATA_W, 8, sample width; MAX_LOCK, 16, max consecutive locked grants.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Per requester i in {0 = host loader, 1 = FIR engine}, the following ports SHALL exist: reqi in 1, request valid; locki in 1, hold grant; wei in 1, write enable; addri in ADDR_W, address; wdatai in DATA_W, write data; gnti out 1, request accepted this cycle; rvalidi out 1, read data valid; rdatai out DATA_W, read data.
REQ-005 mem_en, mem_we  output  1 each  registered memory command strobes.
REQ-006 mem_addr  output  ADDR_W  and mem_wdata  output  DATA_W: registered memory command fields.
REQ-007 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-008 gnt0/gnt1 SHALL be combinational from req, lock state and priority pointer; at most one SHALL be high per cycle.
REQ-009 A request SHALL be accepted only in a cycle where reqi=1 and gnti=1; the requester holds its fields stable until accepted.
REQ-010 Arbitration SHALL be round-robin: a single pointer holds the last-granted index; on contention the other requester wins.
REQ-011 With only one requester active, it SHALL be granted every cycle (no bubble).
REQ-012 States SHALL be: IDLE (no lock); LOCKED0; LOCKED1.
REQ-013 IDLE -> LOCKEDi when requester i is granted with locki=1; the lock counter loads 1.
REQ-014 In LOCKEDi, only requester i SHALL be granted; the counter increments on each grant.
REQ-015 LOCKEDi -> IDLE when locki=0 at a grant, reqi=0, or the counter reaches MAX_LOCK. The grant that reaches MAX_LOCK is the last locked grant; the pointer then favours the other requester.
REQ-016 The accepted command SHALL appear on mem_* at the next rising edge: mem_en=1, mem_we=wei, mem_addr=addri, mem_wdata=wdatai. With no acceptance, mem_en=0 and mem_we=0.
REQ-017 Read latency SHALL be exactly 2 cycles: a read accepted in cycle t gives rvalidi=1 in cycle t+2 only, with rdatai=mem_rdata.
REQ-018 Writes SHALL produce no rvalid.
REQ-019 rdata0/rdata1 SHALL both carry mem_rdata; only rvalid qualifies them.
REQ-020 A read and a write to the same address accepted back-to-back SHALL complete in acceptance order; no reordering or forwarding.

Reset
REQ-021 While rst_n=0, the outputs SHALL be: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid0=rvalid1=0, state=IDLE, lock counter=0, pointer=1 (requester 0 favoured first).
REQ-022 gnt0 and gnt1 SHALL be 0 while rst_n=0.
REQ-023 A reset during an outstanding read SHALL discard it; no rvalid appears after deassertion.

Configuration
REQ-024 With macro FIR_ARB_STATS_EN defined, the block SHALL add outputs gnt_cnt0 and gnt_cnt1 (32 bit, accepted requests per requester) and conflict_cnt (32 bit, cycles with req0=req1=1 where one was not granted).
REQ-025 The statistics counters SHALL be reset to 0 and wrap at 2^32.
REQ-026 Without FIR_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour is identical.

Verification
REQ-027 Host writes addr 0..3 = 8'h05,8'h0A,8'hF6,8'h40 with req1=0 -> gnt0 every cycle; mem_we=1 with matching addr/data one cycle later.
REQ-028 req0 and req1 both held for 4 reads (addr 10, addr 300), no lock, after reset -> grant order 0,1,0,1; each rvalid exactly 2 cycles after its grant with mem_rdata.
REQ-029 FIR holds req1=lock1=1 for 20 reads while req0=1 -> 16 consecutive gnt1, then gnt0 on the next cycle; conflict_cnt=16 with stats enabled.
REQ-030 Read addr 256 (mem=8'hC3) accepted, rst_n pulsed low the next cycle -> rvalid never asserts; all mem_* and counters read 0.
REQ-031 Write addr 256 = 8'h7F then read addr 256 back-to-back from requester 1 -> rvalid1 with rdata1 = 8'h7F.
REQ-032 Lock released mid-burst (lock1 goes 0 on the 5th grant while req0=1) -> next grant goes to requester 0; state returns to IDLE.
